// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the dual-issue fetch-to-decode instruction queue.
// Entries carry the instruction word together with its PC.
package iq_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } iq_entry_t;

  // addi x0,x0,0 -- driven on an empty decode slot
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int IQ_DEFAULT_DEPTH = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Fetch/decode-facing signal bundle of the instruction queue.
// Handshake: fetch may push only while push_ready=1 (a push with push_ready=0 is dropped), decode pops only entries flagged by validD1/validD2; both take effect at the clock edge.
interface instr_queue_if #(parameter int DEPTH = iq_pkg::IQ_DEFAULT_DEPTH);

  logic                               flush;
  logic                               push1;
  logic                               push2;
  logic [31:0]                        InstrF1;
  logic [31:0]                        PCF1;
  logic [31:0]                        InstrF2;
  logic [31:0]                        PCF2;
  logic                               push_ready;
  logic                               pop1;
  logic                               pop2;
  logic                               validD1;
  logic                               validD2;
  logic [31:0]                        InstrD1;
  logic [31:0]                        PCD1;
  logic [31:0]                        PCPlus4D1;
  logic [31:0]                        InstrD2;
  logic [31:0]                        PCD2;
  logic [31:0]                        PCPlus4D2;
  logic [iq_pkg::cnt_w(DEPTH)-1:0]    count;

  // Fetch, decode and redirect logic: drives the requests, observes the queue
  modport master (
    output flush, push1, push2, InstrF1, PCF1, InstrF2, PCF2, pop1, pop2,
    input  push_ready, validD1, validD2, InstrD1, PCD1, PCPlus4D1,
    input  InstrD2, PCD2, PCPlus4D2, count
  );

  // The queue itself
  modport slave (
    input  flush, push1, push2, InstrF1, PCF1, InstrF2, PCF2, pop1, pop2,
    output push_ready, validD1, validD2, InstrD1, PCD1, PCPlus4D1,
    output InstrD2, PCD2, PCPlus4D2, count
  );

endinterface

// File: rtl/instr_queue.sv
// Dual-issue instruction queue: circular buffer written up to two entries per cycle
// by fetch and read up to two oldest entries per cycle by decode; flush empties it.
module instr_queue #(
  parameter int          DEPTH     = iq_pkg::IQ_DEFAULT_DEPTH,
  parameter logic [31:0] NOP_INSTR = iq_pkg::NOP_INSTR
) (
  input  logic           clk,
  input  logic           rst,
  instr_queue_if.slave   bus
);
  import iq_pkg::*;

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  iq_entry_t         mem_q [DEPTH];
  iq_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic              push_ready;
  logic [1:0]        n_push;
  logic [1:0]        n_pop_req;
  logic [1:0]        n_pop;
  logic [PW-1:0]     head_nx;
  logic [PW-1:0]     tail_nx;

  always_comb begin
    push_ready = (count_q <= CW'(DEPTH - 2));
    head_nx    = head_q + PW'(1);
    tail_nx    = tail_q + PW'(1);

    n_push = 2'd0;
    if (push_ready && bus.push1) n_push = bus.push2 ? 2'd2 : 2'd1;

    n_pop_req = 2'd0;
    if (bus.pop1) n_pop_req = bus.pop2 ? 2'd2 : 2'd1;
    // Pops are clipped to what is stored at the start of the cycle; a same-cycle push cannot be popped
    n_pop = (CW'(n_pop_req) > count_q) ? count_q[1:0] : n_pop_req;

    mem_d = mem_q;
    if (n_push != 2'd0) mem_d[tail_q]  = '{instr: bus.InstrF1, pc: bus.PCF1};
    if (n_push == 2'd2) mem_d[tail_nx] = '{instr: bus.InstrF2, pc: bus.PCF2};

    head_d  = head_q + PW'(n_pop);
    tail_d  = tail_q + PW'(n_push);
    count_d = count_q + CW'(n_push) - CW'(n_pop);

    if (bus.flush) begin
      mem_d   = mem_q;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Decode side reads straight from registered state; no bypass from the fetch inputs
  always_comb begin
    bus.push_ready = push_ready;
    bus.count      = count_q;
    bus.validD1    = (count_q >= CW'(1));
    bus.validD2    = (count_q >= CW'(2));

    bus.InstrD1 = NOP_INSTR;
    bus.PCD1    = 32'd0;
    if (bus.validD1) begin
      bus.InstrD1 = mem_q[head_q].instr;
      bus.PCD1    = mem_q[head_q].pc;
    end

    bus.InstrD2 = NOP_INSTR;
    bus.PCD2    = 32'd0;
    if (bus.validD2) begin
      bus.InstrD2 = mem_q[head_nx].instr;
      bus.PCD2    = mem_q[head_nx].pc;
    end

    bus.PCPlus4D1 = bus.PCD1 + 32'd4;
    bus.PCPlus4D2 = bus.PCD2 + 32'd4;
  end

endmodule

// File: tb/tb_instr_queue.sv
// Randomised and directed bench for instr_queue against a queue-based reference model.
module tb_instr_queue;
  import iq_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;

  instr_queue_if #(.DEPTH(DEPTH)) bus();

  instr_queue #(.DEPTH(DEPTH), .NOP_INSTR(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] ref_q [$];   // {instr, pc}, index 0 is oldest
  int n_vec;
  int n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    logic [31:0] e_i1, e_p1, e_i2, e_p2, e_p41, e_p42;
    e_i1 = 32'h0000_0013; e_p1 = 32'd0;
    e_i2 = 32'h0000_0013; e_p2 = 32'd0;
    if (ref_q.size() >= 1) begin e_i1 = ref_q[0][63:32]; e_p1 = ref_q[0][31:0]; end
    if (ref_q.size() >= 2) begin e_i2 = ref_q[1][63:32]; e_p2 = ref_q[1][31:0]; end
    e_p41 = e_p1 + 32'd4;
    e_p42 = e_p2 + 32'd4;
    check_eq({where, ".count"},      64'(bus.count),      64'(ref_q.size()));
    check_eq({where, ".push_ready"}, 64'(bus.push_ready), 64'((DEPTH - ref_q.size()) >= 2));
    check_eq({where, ".validD1"},    64'(bus.validD1),    64'(ref_q.size() >= 1));
    check_eq({where, ".validD2"},    64'(bus.validD2),    64'(ref_q.size() >= 2));
    check_eq({where, ".InstrD1"},    64'(bus.InstrD1),    64'(e_i1));
    check_eq({where, ".PCD1"},       64'(bus.PCD1),       64'(e_p1));
    check_eq({where, ".PCPlus4D1"},  64'(bus.PCPlus4D1),  64'(e_p41));
    check_eq({where, ".InstrD2"},    64'(bus.InstrD2),    64'(e_i2));
    check_eq({where, ".PCD2"},       64'(bus.PCD2),       64'(e_p2));
    check_eq({where, ".PCPlus4D2"},  64'(bus.PCPlus4D2),  64'(e_p42));
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    bus.flush = 1'b0; bus.push1 = 1'b0; bus.push2 = 1'b0;
    bus.InstrF1 = '0; bus.PCF1 = '0; bus.InstrF2 = '0; bus.PCF2 = '0;
    bus.pop1 = 1'b0; bus.pop2 = 1'b0;
  endtask

  // Applies one cycle of stimulus, advances the model, then checks #1 after the edge
  task automatic cycle(input logic f, input logic p1, input logic p2,
                       input logic [31:0] i1, input logic [31:0] pc1,
                       input logic [31:0] i2, input logic [31:0] pc2,
                       input logic q1, input logic q2, input string where);
    int npop;
    bit can_push;
    bus.flush = f; bus.push1 = p1; bus.push2 = p2;
    bus.InstrF1 = i1; bus.PCF1 = pc1; bus.InstrF2 = i2; bus.PCF2 = pc2;
    bus.pop1 = q1; bus.pop2 = q2;
    can_push = (DEPTH - ref_q.size()) >= 2;
    npop = q1 ? (q2 ? 2 : 1) : 0;
    if (npop > ref_q.size()) npop = ref_q.size();
    @(posedge clk);
    #1;
    if (f) begin
      ref_q.delete();
    end else begin
      repeat (npop) void'(ref_q.pop_front());
      if (can_push && p1) begin
        ref_q.push_back({i1, pc1});
        if (p2) ref_q.push_back({i2, pc2});
      end
    end
    idle_inputs();
    check_outputs(where);
  endtask

  task automatic push_dual(input logic [31:0] pc, input string where);
    cycle(1'b0, 1'b1, 1'b1, 32'h1000_0000 | pc, pc, 32'h1000_0000 | (pc + 32'd4), pc + 32'd4,
          1'b0, 1'b0, where);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] last_pc;
    logic [31:0] r_pc1, r_pc2;
    n_vec = 0;
    n_err = 0;
    do_reset();
    check_outputs("reset");
    check_eq("reset.InstrD1_nop", 64'(bus.InstrD1), 64'h13);
    check_eq("reset.PCPlus4D1", 64'(bus.PCPlus4D1), 64'd4);

    // First dual push
    cycle(1'b0, 1'b1, 1'b1, 32'h0050_0093, 32'h0, 32'h00A0_0113, 32'h4, 1'b0, 1'b0, "push2");
    check_eq("push2.PCD2",      64'(bus.PCD2),      64'h4);
    check_eq("push2.PCPlus4D2", 64'(bus.PCPlus4D2), 64'h8);

    // Fill to DEPTH
    push_dual(32'h8,  "fill2");
    push_dual(32'h10, "fill3");
    check_eq("fill3.push_ready", 64'(bus.push_ready), 64'd1);
    push_dual(32'h18, "fill4");
    check_eq("fill4.count",      64'(bus.count),      64'd8);
    check_eq("fill4.push_ready", 64'(bus.push_ready), 64'd0);
    push_dual(32'h20, "full_drop");
    check_eq("full_drop.count", 64'(bus.count), 64'd8);
    cycle(1'b0, 1'b1, 1'b1, 32'hdead_0001, 32'h40, 32'hdead_0002, 32'h44, 1'b1, 1'b0, "pop_at_full");
    check_eq("pop_at_full.count",      64'(bus.count),      64'd7);
    check_eq("pop_at_full.push_ready", 64'(bus.push_ready), 64'd0);
    // count=7 with a pop: push must still be refused
    cycle(1'b0, 1'b1, 1'b0, 32'hdead_0003, 32'h48, 32'h0, 32'h0, 1'b1, 1'b0, "pop_at_7");
    check_eq("pop_at_7.count", 64'(bus.count), 64'd6);

    // Drain, then walk the pointers to 7 so the next dual push straddles the wrap
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1, "drain");
    check_eq("drain.count", 64'(bus.count), 64'd0);
    // push and pop at count=0: only the push lands
    cycle(1'b0, 1'b1, 1'b0, 32'h2000_0000, 32'h100, 0, 0, 1'b1, 1'b1, "push_pop_empty");
    check_eq("push_pop_empty.count", 64'(bus.count), 64'd1);
    for (int i = 1; i < 7; i++)
      cycle(1'b0, 1'b1, 1'b0, 32'h2000_0000 + i, 32'h100 + 32'(4 * i), 0, 0, 1'b1, 1'b0, "walk");
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, "walk_empty");
    for (int i = 0; i < 3; i++) push_dual(32'h200 + 32'(8 * i), "wrap_push");
    last_pc = 32'h1fc;
    for (int i = 0; i < 4; i++) begin
      if (bus.validD1) begin
        check_eq("wrap.order1", 64'(bus.PCD1 > last_pc), 64'd1);
        last_pc = bus.PCD1;
      end
      if (bus.validD2) begin
        check_eq("wrap.order2", 64'(bus.PCD2 > last_pc), 64'd1);
        last_pc = bus.PCD2;
      end
      cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1, "wrap_pop");
    end
    check_eq("wrap.last_pc", 64'(last_pc), 64'h214);

    // Flush at count=5 with simultaneous push and pop
    push_dual(32'h300, "pre_flush");
    push_dual(32'h308, "pre_flush");
    cycle(1'b0, 1'b1, 1'b0, 32'h3000_0000, 32'h310, 0, 0, 1'b0, 1'b0, "pre_flush");
    check_eq("pre_flush.count", 64'(bus.count), 64'd5);
    cycle(1'b1, 1'b1, 1'b1, 32'hbad0_0001, 32'h500, 32'hbad0_0002, 32'h504, 1'b1, 1'b0, "flush");
    check_eq("flush.count",   64'(bus.count),   64'd0);
    check_eq("flush.validD1", 64'(bus.validD1), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h4000_0001, 32'h600, 0, 0, 1'b0, 1'b0, "post_flush");
    check_eq("post_flush.InstrD1", 64'(bus.InstrD1), 64'h4000_0001);

    // Asynchronous reset mid-stream at count=4
    push_dual(32'h700, "pre_rst");
    push_dual(32'h708, "pre_rst");
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, "pre_rst");
    check_eq("pre_rst.count", 64'(bus.count), 64'd4);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst.validD1", 64'(bus.validD1), 64'd0);
    check_eq("async_rst.count",   64'(bus.count),   64'd0);
    ref_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 32'h5000_0001, 32'h800, 0, 0, 1'b0, 1'b0, "post_rst");
    check_eq("post_rst.validD1", 64'(bus.validD1), 64'd1);

    // PC wrap-around arithmetic
    cycle(1'b0, 1'b1, 1'b0, 32'h6000_0001, 32'hFFFF_FFFC, 0, 0, 1'b1, 1'b0, "pc_wrap");
    check_eq("pc_wrap.PCPlus4D1", 64'(bus.PCPlus4D1), 64'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r_pc1 = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 2 << 2;
      r_pc2 = r_pc1 + 32'd4;
      cycle(1'b0 == ($urandom_range(0, 40) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, r_pc1, $urandom, r_pc2,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Dual-issue fetch-to-decode instruction queue.
- Accepts up to two {instruction, PC} pairs per cycle from the fetch stage (InstrF1/PCF1, InstrF2/PCF2) and presents the two oldest entries to decode each cycle.
- Decouples fetch stalls from decode stalls, and drives fetch's enables through push_ready.
- Branch redirects from execute use flush to discard all queued entries.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- NOP_INSTR, 32'h00000013, value driven on instruction outputs when the slot is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  discard all entries (branch/jump redirect)
- push1  in  1  fetch slot 1 valid
- push2  in  1  fetch slot 2 valid; honoured only with push1
- InstrF1  in  32  slot 1 instruction
- PCF1  in  32  slot 1 PC
- InstrF2  in  32  slot 2 instruction
- PCF2  in  32  slot 2 PC
- push_ready  out  1  at least 2 free entries; fetch en1/en2 derive from this
- pop1  in  1  decode consumes oldest entry
- pop2  in  1  decode consumes second-oldest entry; honoured only with pop1
- validD1  out  1  oldest entry present
- validD2  out  1  second-oldest entry present
- InstrD1  out  32  oldest instruction
- PCD1  out  32  oldest PC
- PCPlus4D1  out  32  PCD1 + 4
- InstrD2  out  32  second-oldest instruction
- PCD2  out  32  second-oldest PC
- PCPlus4D2  out  32  PCD2 + 4
- count  out  $clog2(DEPTH)+1  occupancy, for debug/perf counters

Behaviour:
- Storage: circular buffer of DEPTH entries {instr[31:0], pc[31:0]}. Head pointer (oldest) and tail pointer (next free), each $clog2(DEPTH) bits. Both wrap modulo DEPTH. count is 0..DEPTH.
- Reset (async, rst=1): head=0, tail=0, count=0. validD1=validD2=0, InstrD1/InstrD2=NOP_INSTR, PCD*=0, PCPlus4D*=4, push_ready=1. Reset mid-operation drops all contents immediately.
- push_ready = (DEPTH - count) >= 2. It is combinational from the registered count and does not credit same-cycle pops.
- Push, when push_ready=1:
  - push1 writes slot 1 at tail.
  - push1&push2 writes slot 1 at tail and slot 2 at tail+1, in that order.
  - push2 without push1 is ignored.
  - Pushes while push_ready=0 are dropped; fetch must hold.
- Pop:
  - pops = pop1 + (pop1 & pop2), clipped to the available count. pop2 with count<2 pops only one entry.
  - Pop with count=0 is ignored.
- Next state, same cycle: count <= count + pushes - pops. head advances by pops, tail advances by pushes, both modulo DEPTH.
- Latency:
  - A pushed entry appears on the D outputs on the next cycle at the earliest.
  - No bypass from F inputs to D outputs.
  - Pop takes effect at the clock edge; outputs show the new oldest entries after the edge.
- Outputs are combinational reads of head and head+1:
  - validD1 = count>=1; validD2 = count>=2.
  - An invalid slot drives NOP_INSTR, PC 0, PCPlus4 4.
- PC arithmetic: PCPlus4 is 32-bit wrap-around; 32'hFFFFFFFC + 4 = 0.
- Flush has highest priority below reset:
  - At the next edge: head=tail=count=0.
  - Same-cycle pushes and pops are discarded.
  - validD* drop in the following cycle.
- Full/empty boundaries:
  - count=DEPTH-1: push_ready=0, even with a simultaneous pop.
  - count=0 with push and pop in the same cycle: only the push takes effect.
- Wrap: tail and head crossing DEPTH-1 to 0 must preserve FIFO order, including a dual push that straddles the wrap (slot 1 at DEPTH-1, slot 2 at 0).

Decomposition:
- Package iq_pkg holds:
  - typedef iq_entry_t {logic [31:0] instr; logic [31:0] pc;}
  - constant NOP_INSTR
  - localparam helpers for pointer width
- No sub-module: storage, pointers and count live in one module.
- The entry array is a plain register array, not instr_mem, so that the dual write/dual read has no port conflict.

Test Plan:
- Reset, then idle -> validD1=validD2=0, InstrD1=32'h00000013, PCPlus4D1=4, push_ready=1, count=0.
- Dual push {0x00500093, PC 0x0}, {0x00A00113, PC 0x4}, no pop -> next cycle: validD1=validD2=1, PCD2=0x4, PCPlus4D2=0x8, count=2.
- Fill DEPTH=8 with dual pushes -> after the 3rd push (count=6) push_ready=1. After the 4th (count=8) push_ready=0. A further push is dropped and count stays 8. pop1 alone gives count=7, push_ready still 0.
- Dual push straddling the wrap (tail=7) followed by 4 dual pops -> PCs emerge in strictly increasing order with none lost.
- flush asserted together with push1&push2 and pop1 at count=5 -> next cycle count=0, validD1=0, head=tail=0. The following push lands as the oldest entry.
- Assert rst mid-stream (count=4) asynchronously between edges -> validD1 drops before the next clk edge and count=0. After deassert, the first push appears next cycle.
